countdown_timer: RTL and testbench

- Loadable down-counter and timer. It is the decrementing counterpart of the team's 2-bit up-counter.
- Software or a controlling FSM loads a start value, issues start, and receives a one-cycle done pulse when the count reaches zero.
- Used as a delay/timeout generator next to the counter blocks, on the same single clock domain.

---
 rtl/countdown_timer.sv | 93 +++++++++
 tb/tb_countdown_timer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter: load a start value, start, and get a one-cycle done pulse at zero.
// Define AUTO_RELOAD_EN to make the terminal count reload the last loaded value (periodic tick).
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t state;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            count  <= load_val;
`ifdef AUTO_RELOAD_EN
            reload <= load_val;
`endif
          end else if (start) begin
            // Starting from zero completes at once without entering RUN.
            if (count != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done  <= 1'b1;
            end
          end
        end

        // RUN and PAUSE differ only in whether the current cycle decremented;
        // releasing hold decrements on the very edge that samples it low.
        RUN, PAUSE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (hold) begin
            state <= PAUSE;
          end else if (count == WIDTH'(1)) begin
            done <= 1'b1;
`ifdef AUTO_RELOAD_EN
            if (reload != '0) begin
              count <= reload;
              state <= RUN;
            end else begin
              count <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end
`else
            count <= '0;
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end else begin
            count <= count - WIDTH'(1);
            state <= RUN;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed steps push expected outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_countdown_timer;

  logic       clk, reset, load, start, hold, abort;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       busy, done;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   step     = 0;

  countdown_timer #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .hold     (hold),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: one expected entry per edge, sampled 2 ns after the edge.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({count, busy, done} !== mon_e) begin
        failures++;
        $display("FAIL step%0d: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                 step, count, busy, done, mon_e.count, mon_e.busy, mon_e.done);
      end
    end
  end

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {count,busy,done}=%h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic ld, input logic [7:0] lv, input logic st, input logic hd,
                     input logic ab, input logic [7:0] ec, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    load = ld; load_val = lv; start = st; hold = hd; abort = ab;
    e.count = ec; e.busy = eb; e.done = ed;
    sb.push_back(e);
    step++;
  endtask

  task automatic idle(input logic [7:0] ec, input logic eb, input logic ed);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, ec, eb, ed);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_val = 8'd0; start = 1'b0; hold = 1'b0; abort = 1'b0;
    #5  chk("reset_t5",  {count, busy, done}, 10'h000);
    #20 chk("reset_t25", {count, busy, done}, 10'h000);
    #5  reset = 1'b0;

    // load 0 then start: immediate done, never busy
    cyc(1, 8'd0, 0, 0, 0, 8'd0, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 8'd0, 0, 1);
    idle(8'd0, 0, 0);
    // load and start together: only the load happens
    cyc(1, 8'd7, 1, 0, 0, 8'd7, 0, 0);
    idle(8'd7, 0, 0);
    // load/start ignored while running, abort from PAUSE keeps count
    cyc(0, 8'd0, 1, 0, 0, 8'd7, 1, 0);
    cyc(1, 8'd3, 0, 0, 0, 8'd6, 1, 0);
    cyc(0, 8'd0, 1, 0, 0, 8'd5, 1, 0);
    cyc(0, 8'd0, 0, 1, 0, 8'd5, 1, 0);
    cyc(0, 8'd0, 0, 1, 1, 8'd5, 0, 0);
    idle(8'd5, 0, 0);

`ifndef AUTO_RELOAD_EN
    // load 5, start: 5,4,3,2,1,0 with done at 0
    cyc(1, 8'd5, 0, 0, 0, 8'd5, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 8'd5, 1, 0);
    idle(8'd4, 1, 0); idle(8'd3, 1, 0); idle(8'd2, 1, 0); idle(8'd1, 1, 0);
    idle(8'd0, 0, 1);
    idle(8'd0, 0, 0);
    // load 4, hold 3 cycles at count 2: done 3 cycles late
    cyc(1, 8'd4, 0, 0, 0, 8'd4, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 8'd4, 1, 0);
    idle(8'd3, 1, 0); idle(8'd2, 1, 0);
    cyc(0, 8'd0, 0, 1, 0, 8'd2, 1, 0);
    cyc(0, 8'd0, 0, 1, 0, 8'd2, 1, 0);
    cyc(0, 8'd0, 0, 1, 0, 8'd2, 1, 0);
    idle(8'd1, 1, 0);
    idle(8'd0, 0, 1);
    idle(8'd0, 0, 0);
    // load 10, abort at 6, restart finishes 6->0
    cyc(1, 8'd10, 0, 0, 0, 8'd10, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 8'd10, 1, 0);
    idle(8'd9, 1, 0); idle(8'd8, 1, 0); idle(8'd7, 1, 0); idle(8'd6, 1, 0);
    cyc(0, 8'd0, 0, 0, 1, 8'd6, 0, 0);
    idle(8'd6, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 8'd6, 1, 0);
    idle(8'd5, 1, 0); idle(8'd4, 1, 0); idle(8'd3, 1, 0); idle(8'd2, 1, 0); idle(8'd1, 1, 0);
    idle(8'd0, 0, 1);
    idle(8'd0, 0, 0);
    // maximum value counts all the way down
    cyc(1, 8'd255, 0, 0, 0, 8'd255, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 8'd255, 1, 0);
    for (int i = 254; i >= 1; i--) idle(8'(i), 1, 0);
    idle(8'd0, 0, 1);
    idle(8'd0, 0, 0);
`else
    // periodic tick every 3 cycles, abort is the way out
    cyc(1, 8'd3, 0, 0, 0, 8'd3, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 8'd3, 1, 0);
    idle(8'd2, 1, 0); idle(8'd1, 1, 0); idle(8'd3, 1, 1);
    idle(8'd2, 1, 0); idle(8'd1, 1, 0); idle(8'd3, 1, 1);
    idle(8'd2, 1, 0);
    cyc(0, 8'd0, 0, 0, 1, 8'd2, 0, 0);
    idle(8'd2, 0, 0);
`endif

    // asynchronous reset in the middle of a run
    cyc(1, 8'd3, 0, 0, 0, 8'd3, 0, 0);
    cyc(0, 8'd0, 1, 0, 0, 8'd3, 1, 0);
    idle(8'd2, 1, 0);
    @(negedge clk);
    #3 reset = 1'b1;
    #2 chk("reset_midrun", {count, busy, done}, 10'h000);
    @(negedge clk);
    chk("reset_held", {count, busy, done}, 10'h000);
    reset = 1'b0;
    cyc(0, 8'd0, 1, 0, 0, 8'd0, 0, 1);
    idle(8'd0, 0, 0);

    begin
      int k = 0;
      while (sb.size() > 0 && k < 10) begin
        @(posedge clk);
        k++;
      end
      #3;
      if (sb.size() != 0) begin
        failures++;
        $display("FAIL drain: %0d expected entries left, want 0", sb.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
